// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI CPU bridge
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_RELEASE
  } eng_state_t;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;

  function automatic logic [15:0] status_word(input logic busy, input logic full,
                                              input logic empty);
    logic [15:0] w;
    w             = '0;
    w[STAT_BUSY]  = busy;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    return w;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// rtl/spi_tx_fifo.sv - transmit word queue between CPU writes and the SPI engine
module spi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_cpu_bridge.sv
// rtl/spi_cpu_bridge.sv - CPU register port that queues writes and serialises reads onto an SPI master
module spi_cpu_bridge
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        stall_o,
  output logic        spi_start_o,
  output logic        spi_rwb_o,
  output logic [15:0] spi_wdata_o,
  input  logic [15:0] spi_rdata_i,
  input  logic        spi_halt_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  eng_state_t    state_q;
  eng_state_t    state_d;
  logic          start_d;
  logic          rwb_d;
  logic [15:0]   wdata_d;
  logic [15:0]   rd_word_q;
  logic [15:0]   rd_word_d;

  logic          data_wr;
  logic          data_rd;
  logic          stat_rd;
  logic          fifo_has_room;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          read_done;

  assign data_wr = sel_i & we_i & (addr_i == ADDR_DATA);
  assign data_rd = sel_i & ~we_i & (addr_i == ADDR_DATA);
  assign stat_rd = sel_i & ~we_i & (addr_i == ADDR_STATUS);

  // Room is judged on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_has_room = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push     = data_wr & fifo_has_room;
  assign read_done     = (state_q == ST_RELEASE) & spi_rwb_o;

  spi_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (16)
  ) u_tx_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .push      (fifo_push),
    .push_data (wdata_i),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      spi_start_o <= 1'b0;
      spi_rwb_o   <= 1'b0;
      spi_wdata_o <= '0;
      rd_word_q   <= '0;
    end else begin
      state_q     <= state_d;
      spi_start_o <= start_d;
      spi_rwb_o   <= rwb_d;
      spi_wdata_o <= wdata_d;
      rd_word_q   <= rd_word_d;
    end
  end

  // Queued writes always drain before a pending read is launched.
  always_comb begin
    state_d   = state_q;
    start_d   = spi_start_o;
    rwb_d     = spi_rwb_o;
    wdata_d   = spi_wdata_o;
    rd_word_d = rd_word_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          wdata_d  = fifo_head;
          rwb_d    = 1'b0;
          start_d  = 1'b1;
          state_d  = ST_START;
        end else if (data_rd) begin
          rwb_d   = 1'b1;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (spi_halt_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!spi_halt_i) begin
          if (spi_rwb_o) rd_word_d = spi_rdata_i;
          start_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stall_o = (data_wr & ~fifo_has_room) | (data_rd & ~read_done);

  always_comb begin
    rdata_o = '0;
    if (stat_rd) begin
      rdata_o = status_word(state_q != ST_IDLE, fifo_full, fifo_empty);
    end else if (data_rd && read_done) begin
      rdata_o = rd_word_q;
    end
  end

endmodule
